cpa_pipe: RTL and testbench

CPA_PIPE -- requirements
Module: cpa_pipe

---
 rtl/cpa_pipe.sv | 113 +++++++++++
 tb/tb_cpa_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpa_pipe.sv
// Pipelined carry-propagate adder/subtractor.
// Each stage adds one SEG-bit slice and passes a single registered carry forward.
// Operands travel with the operation, so slice k is consumed k cycles after
// acceptance. Finished sum slices travel along until all slices reach the output
// together. The valid/ready handshake stalls every stage at once.
module cpa_pipe #(
  parameter int unsigned BITS   = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            co,
  output logic            ovf
);

  localparam int unsigned SEG  = BITS / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage state: operands, partial sum, carry into the next slice, valid.
  logic [BITS-1:0]   op_a [STAGES];
  logic [BITS-1:0]   op_b [STAGES];
  logic [BITS-1:0]   part [STAGES];
  logic [STAGES-1:0] cy;
  logic [STAGES-1:0] vld;

  logic [BITS-1:0]   nx_a [STAGES];
  logic [BITS-1:0]   nx_b [STAGES];
  logic [BITS-1:0]   nx_s [STAGES];
  logic [STAGES-1:0] nx_c;
  logic [STAGES-1:0] nx_v;

  logic [BITS-1:0]   src_a;
  logic [BITS-1:0]   src_b;
  logic [BITS-1:0]   src_s;
  logic              src_c;
  logic              src_v;
  logic [SEG:0]      seg;
  logic              advance;

  assign advance  = ~vld[LAST] | out_ready;
  assign in_ready = advance;

  assign out_valid = vld[LAST];
  assign sum       = part[LAST];
  assign co        = cy[LAST];
  assign ovf       = (op_a[LAST][BITS-1] == op_b[LAST][BITS-1]) &
                     (part[LAST][BITS-1] != op_a[LAST][BITS-1]);

  // Next-state of every stage: add slice k using the carry registered by stage k-1.
  always_comb begin
    src_a = '0;
    src_b = '0;
    src_s = '0;
    src_c = 1'b0;
    src_v = 1'b0;
    seg   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Idle input cycles load zeros so the operand pins never leak into state.
        src_a = in_valid ? a : '0;
        src_b = in_valid ? (sub ? ~b : b) : '0;
        src_s = '0;
        src_c = in_valid & (sub | ci);
        src_v = in_valid;
      end else begin
        src_a = op_a[k-1];
        src_b = op_b[k-1];
        src_s = part[k-1];
        src_c = cy[k-1];
        src_v = vld[k-1];
      end
      seg = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]} +
            {{SEG{1'b0}}, src_c};
      nx_a[k] = src_a;
      nx_b[k] = src_b;
      nx_s[k] = src_s;
      nx_s[k][k*SEG +: SEG] = seg[SEG-1:0];
      nx_c[k] = seg[SEG];
      nx_v[k] = src_v;
    end
  end

  // Pipeline registers: cleared by reset, frozen as a whole while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
        part[k] <= '0;
      end
      cy  <= '0;
      vld <= '0;
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        op_a[k] <= nx_a[k];
        op_b[k] <= nx_b[k];
        part[k] <= nx_s[k];
      end
      cy  <= nx_c;
      vld <= nx_v;
    end
  end

endmodule

// File: tb/tb_cpa_pipe.sv
// Scoreboard bench for cpa_pipe (BITS=32, STAGES=4).
module tb_cpa_pipe;

  localparam int unsigned BITS = 32;
  localparam int unsigned LAT  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            ci;
  logic            sub;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] sum;
  logic            co;
  logic            ovf;

  cpa_pipe #(.BITS(BITS), .STAGES(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BITS-1:0] s;
    logic            c;
    logic            o;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   strict   = 1'b1;

  logic            held;
  logic [BITS-1:0] held_sum;
  logic            held_co;
  logic            held_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model in plain signed/unsigned arithmetic.
  function automatic exp_t model(logic [BITS-1:0] x, logic [BITS-1:0] y,
                                 logic cin, logic md);
    exp_t   e;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint sr;
    longint ur;
    if (md) begin
      ur  = longint'(x) - longint'(y);
      e.c = (x >= y);
      sr  = sx - sy;
    end else begin
      ur  = longint'(x) + longint'(y) + longint'(cin);
      e.c = ur[BITS];
      sr  = sx + sy + longint'(cin);
    end
    e.s   = ur[BITS-1:0];
    e.o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, well away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t r;
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_sum", {32'd0, sum}, {32'd0, held_sum});
        check("hold_flags", {62'd0, co, ovf}, {62'd0, held_co, held_ovf});
      end
      if (out_valid && !out_ready) check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (in_valid && in_ready) begin
        e     = model(a, b, ci, sub);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          r = exp_q.pop_front();
          check("sum", {32'd0, sum}, {32'd0, r.s});
          check("co", {63'd0, co}, {63'd0, r.c});
          check("ovf", {63'd0, ovf}, {63'd0, r.o});
          if (strict) check("latency", 64'(cyc - r.cyc), 64'(LAT));
        end
      end
      held     = out_valid && !out_ready;
      held_sum = sum;
      held_co  = co;
      held_ovf = ovf;
    end
  end

  task automatic drive(bit v, logic [BITS-1:0] x, logic [BITS-1:0] y, logic cin, logic md);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = x;
    b        = y;
    ci       = cin;
    sub      = md;
  endtask

  task automatic drive_rand(bit v);
    drive(v, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int n;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) check("drain_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    held      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_flags", {62'd0, co, ovf}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Full carry ripple, then signed overflow followed by a subtract.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain();

    // Back-to-back random operations.
    for (int i = 0; i < 16; i++) drive_rand(1'b1);
    drain();

    // Alternating bubbles.
    for (int i = 0; i < 12; i++) drive_rand(i % 2 == 0);
    drain();

    // Output stall with a full pipeline; inputs keep toggling meanwhile.
    strict = 1'b0;
    for (int i = 0; i < 6; i++) drive_rand(1'b1);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_rand(1'b1);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive_rand(1'b1);
    for (int i = 0; i < 20; i++) begin
      drive_rand($urandom_range(0, 1) == 1);
      #1 out_ready = ($urandom_range(0, 2) != 0);
    end
    #1 out_ready = 1'b1;
    drain();
    strict = 1'b1;

    // Reset with three operations in flight: none of them may come out.
    for (int i = 0; i < 3; i++) drive_rand(1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum", {32'd0, sum}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (8) @(negedge clk);

    // Random traffic after reset.
    for (int i = 0; i < 16; i++) drive_rand($urandom_range(0, 3) != 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
